// File: rtl/prog_loader_if.sv
// Host byte-stream and instruction-memory write bundle for the program loader.
interface prog_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] inst_address;
    logic [7:0] inst_data;
    logic       inst_we;
    logic       cpu_rst_n;
    logic       busy;
    logic       done;
    logic       error;

    modport master (
        output in_data, in_valid,
        input  in_ready, inst_address, inst_data, inst_we, cpu_rst_n, busy, done, error
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, inst_address, inst_data, inst_we, cpu_rst_n, busy, done, error
    );
endinterface

// File: rtl/prog_loader.sv
// Framed program loader: parses SYNC/ADDR/LEN/DATA/CHK from a host byte stream and
// writes the payload into CPU instruction memory while holding the CPU in reset.
module prog_loader (
    input  logic         clk,
    input  logic         rst_n,
    prog_loader_if.slave bus
);
    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StAddr = 3'd1;
    localparam logic [2:0] StLen  = 3'd2;
    localparam logic [2:0] StData = 3'd3;
    localparam logic [2:0] StChk  = 3'd4;
    localparam logic [2:0] StDone = 3'd5;
    localparam logic [2:0] StErr  = 3'd6;

    localparam logic [7:0] Sync   = 8'hA5;
    localparam logic [7:0] MaxLen = 8'h80;

    logic [2:0] state_q, state_d;
    logic [6:0] addr_q, addr_d;
    logic [7:0] count_q, count_d;
    logic [7:0] sum_q, sum_d;
    logic [6:0] inst_address_q, inst_address_d;
    logic [7:0] inst_data_q, inst_data_d;
    logic       inst_we_q, inst_we_d;
    logic       cpu_rst_n_q, cpu_rst_n_d;
    logic       done_q, done_d;
    logic       error_q, error_d;

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        count_d        = count_q;
        sum_d          = sum_q;
        inst_address_d = inst_address_q;
        inst_data_d    = inst_data_q;
        inst_we_d      = 1'b0;
        cpu_rst_n_d    = cpu_rst_n_q;
        done_d         = done_q;
        error_d        = error_q;

        // in_ready is tied high, so in_valid alone marks an accepted byte.
        if (bus.in_valid) begin
            case (state_q)
                StAddr: begin
                    if (bus.in_data[7]) begin
                        state_d = StErr;
                        error_d = 1'b1;
                    end else begin
                        addr_d  = bus.in_data[6:0];
                        sum_d   = bus.in_data;
                        state_d = StLen;
                    end
                end
                StLen: begin
                    if (bus.in_data == 8'h00 || bus.in_data > MaxLen) begin
                        state_d = StErr;
                        error_d = 1'b1;
                    end else begin
                        count_d = bus.in_data;
                        sum_d   = sum_q + bus.in_data;
                        state_d = StData;
                    end
                end
                StData: begin
                    inst_we_d      = 1'b1;
                    inst_address_d = addr_q;
                    inst_data_d    = bus.in_data;
                    addr_d         = addr_q + 7'd1;
                    sum_d          = sum_q + bus.in_data;
                    count_d        = count_q - 8'd1;
                    if (count_q == 8'd1) state_d = StChk;
                end
                StChk: begin
                    if (bus.in_data == sum_q) begin
                        state_d     = StDone;
                        done_d      = 1'b1;
                        cpu_rst_n_d = 1'b1;
                    end else begin
                        state_d = StErr;
                        error_d = 1'b1;
                    end
                end
                default: begin
                    // Idle, Done and Err only react to SYNC; other bytes are line noise.
                    if (bus.in_data == Sync) begin
                        state_d     = StAddr;
                        done_d      = 1'b0;
                        error_d     = 1'b0;
                        cpu_rst_n_d = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            addr_q         <= 7'd0;
            count_q        <= 8'd0;
            sum_q          <= 8'd0;
            inst_address_q <= 7'd0;
            inst_data_q    <= 8'd0;
            inst_we_q      <= 1'b0;
            cpu_rst_n_q    <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            count_q        <= count_d;
            sum_q          <= sum_d;
            inst_address_q <= inst_address_d;
            inst_data_q    <= inst_data_d;
            inst_we_q      <= inst_we_d;
            cpu_rst_n_q    <= cpu_rst_n_d;
            done_q         <= done_d;
            error_q        <= error_d;
        end
    end

    assign bus.in_ready     = 1'b1;
    assign bus.inst_address = inst_address_q;
    assign bus.inst_data    = inst_data_q;
    assign bus.inst_we      = inst_we_q;
    assign bus.cpu_rst_n    = cpu_rst_n_q;
    assign bus.done         = done_q;
    assign bus.error        = error_q;
    assign bus.busy         = (state_q == StAddr) || (state_q == StLen) ||
                              (state_q == StData) || (state_q == StChk);
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames are streamed in and every instruction-memory
// write is logged on the falling edge and compared with hand-computed expectations.
module tb_prog_loader;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    prog_loader_if bus ();

    prog_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [6:0] wa[$];
    logic [7:0] wd[$];
    int         wc[$];
    always @(negedge clk) begin
        if (bus.inst_we === 1'b1) begin
            wa.push_back(bus.inst_address);
            wd.push_back(bus.inst_data);
            wc.push_back(cyc);
        end
    end

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] frame[$];
    logic [6:0] ea[$];
    logic [7:0] ed[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; leaves time at posedge+1 after the byte is accepted.
    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input bit gaps);
        foreach (frame[i]) send(frame[i], gaps ? (i % 3) + 1 : 0);
    endtask

    task automatic check_writes(input string tag, input int base, input bit consec);
        check({tag, "_count"}, wa.size() - base, ea.size());
        for (int i = 0; i < ea.size() && base + i < wa.size(); i++) begin
            check({tag, "_addr"}, wa[base+i], ea[i]);
            check({tag, "_data"}, wd[base+i], ed[i]);
            if (consec && i > 0) check({tag, "_b2b"}, wc[base+i] - wc[base+i-1], 1);
        end
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input logic c);
        check({tag, "_done"}, bus.done, d);
        check({tag, "_error"}, bus.error, e);
        check({tag, "_cpu_rst_n"}, bus.cpu_rst_n, c);
        check({tag, "_busy"}, bus.busy, 1'b0);
        check({tag, "_we"}, bus.inst_we, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;

        // Reset values
        #1 rst_n = 1'b0;
        #2;
        check("rst_we", bus.inst_we, 1'b0);
        check("rst_addr", bus.inst_address, 7'h00);
        check("rst_data", bus.inst_data, 8'h00);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check_status("rst", 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_cpu_rst_n", bus.cpu_rst_n, 1'b0);

        // Good frame, gap-free; checksum 10+03+11+22+33 = 79
        base = wa.size();
        send(8'hA5, 0);
        check("f1_busy_after_sync", bus.busy, 1'b1);
        check("f1_cpu_rst_low", bus.cpu_rst_n, 1'b0);
        send(8'h10, 0);
        send(8'h03, 0);
        send(8'h11, 0);
        check("f1_lat_we", bus.inst_we, 1'b1);
        check("f1_lat_addr", bus.inst_address, 7'h10);
        check("f1_lat_data", bus.inst_data, 8'h11);
        send(8'h22, 0);
        send(8'h33, 0);
        send(8'h79, 0);
        ea = '{7'h10, 7'h11, 7'h12};
        ed = '{8'h11, 8'h22, 8'h33};
        check_writes("f1", base, 1'b1);
        check_status("f1", 1'b1, 1'b0, 1'b1);
        check("f1_hold_addr", bus.inst_address, 7'h12);
        check("f1_hold_data", bus.inst_data, 8'h33);

        // Address wrap; checksum 7E+03+01+02+03 = 87
        base  = wa.size();
        frame = '{8'hA5, 8'h7E, 8'h03, 8'h01, 8'h02, 8'h03, 8'h87};
        send_frame(1'b0);
        ea = '{7'h7E, 7'h7F, 7'h00};
        ed = '{8'h01, 8'h02, 8'h03};
        check_writes("wrap", base, 1'b1);
        check_status("wrap", 1'b1, 1'b0, 1'b1);

        // Bad checksum: correct sum is 00, 01 sent; the write is not rolled back
        base  = wa.size();
        frame = '{8'hA5, 8'h00, 8'h01, 8'hFF, 8'h01};
        send_frame(1'b0);
        ea = '{7'h00};
        ed = '{8'hFF};
        check_writes("badchk", base, 1'b1);
        check_status("badchk", 1'b0, 1'b1, 1'b0);

        // Illegal header and lengths
        base  = wa.size();
        frame = '{8'hA5, 8'h80};
        send_frame(1'b0);
        check("hdr_writes", wa.size() - base, 0);
        check_status("hdr", 1'b0, 1'b1, 1'b0);
        frame = '{8'hA5, 8'h00, 8'h00};
        send_frame(1'b0);
        check("len0_writes", wa.size() - base, 0);
        check_status("len0", 1'b0, 1'b1, 1'b0);
        frame = '{8'hA5, 8'h00, 8'h81};
        send_frame(1'b0);
        check("len81_writes", wa.size() - base, 0);
        check_status("len81", 1'b0, 1'b1, 1'b0);

        // Idle noise, then a frame carrying A5 as payload; checksum 05+02+A5+01 = AD
        send(8'h00, 0);
        send(8'h5A, 0);
        check_status("noise", 1'b0, 1'b1, 1'b0);
        base  = wa.size();
        frame = '{8'hA5, 8'h05, 8'h02, 8'hA5, 8'h01, 8'hAD};
        send_frame(1'b0);
        ea = '{7'h05, 7'h06};
        ed = '{8'hA5, 8'h01};
        check_writes("noise_frame", base, 1'b1);
        check_status("noise_frame", 1'b1, 1'b0, 1'b1);

        // Reset right after the second DATA byte is accepted
        base  = wa.size();
        frame = '{8'hA5, 8'h20, 8'h03, 8'hAA, 8'hBB};
        send_frame(1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_addr", bus.inst_address, 7'h00);
        check("midrst_data", bus.inst_data, 8'h00);
        check_status("midrst", 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        ea = '{7'h20};
        ed = '{8'hAA};
        check_writes("midrst", base, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_status("midrst_release", 1'b0, 1'b0, 1'b0);

        // First frame again with 1-3 cycle in_valid gaps
        base  = wa.size();
        frame = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h79};
        send_frame(1'b1);
        ea = '{7'h10, 7'h11, 7'h12};
        ed = '{8'h11, 8'h22, 8'h33};
        check_writes("gaps", base, 1'b0);
        check_status("gaps", 1'b1, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
